// File: rtl/typing_level_controller.sv
// Typing-game sequencer: holds the level title, then checks typed keys one by
// one against the level sentence read from an external text ROM.
module typing_level_controller #(
   parameter int TITLE_CYCLES = 100_000_000,
   parameter int NUM_LEVELS   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       key_valid,
   input  logic [7:0] key_ascii,
   input  logic [7:0] exp_char,
   output logic [7:0] txt_addr,
   output logic [1:0] level,
   output logic [5:0] cursor,
   output logic [7:0] errors,
   output logic [1:0] screen_sel,
   output logic       key_ok,
   output logic       key_bad,
   output logic       level_done,
   output logic       game_done
);

   localparam int            CW         = (TITLE_CYCLES > 1) ? $clog2(TITLE_CYCLES) : 1;
   localparam logic [CW-1:0] TITLE_LAST = CW'(TITLE_CYCLES - 1);
   localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS);

   typedef enum logic [2:0] {
      S_IDLE, S_TITLE, S_FETCH, S_CHECK_END, S_WAIT_KEY, S_LEVEL_END, S_GAME_DONE
   } state_t;

   typedef struct packed {
      logic       vld;
      logic [7:0] ascii;
   } key_t;

   state_t        state, state_nxt;
   logic [CW-1:0] title_cnt, title_cnt_nxt;
   key_t          pend, pend_nxt, cur_key;
   logic [7:0]    exp_q, exp_nxt;
   logic [7:0]    txt_addr_nxt, errors_nxt;
   logic [1:0]    level_nxt, screen_sel_nxt;
   logic [5:0]    cursor_nxt;
   logic          key_ok_nxt, key_bad_nxt, level_done_nxt, game_done_nxt;
   logic          key_match;

   function automatic logic [7:0] to_upper(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
   endfunction

   // A buffered key always wins over a live strobe in the same cycle.
   always_comb begin
      cur_key = pend;
      if (!pend.vld) begin
         cur_key.vld   = key_valid;
         cur_key.ascii = key_ascii;
      end
   end

   assign key_match = cur_key.vld && (to_upper(cur_key.ascii) == exp_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_GAME_DONE: if (start) state_nxt = S_TITLE;
         S_TITLE:             if (title_cnt == TITLE_LAST) state_nxt = S_FETCH;
         S_FETCH:             state_nxt = S_CHECK_END;
         S_CHECK_END:         state_nxt = (exp_char == 8'h00) ? S_LEVEL_END : S_WAIT_KEY;
         S_WAIT_KEY: begin
            if (key_match) state_nxt = (cursor == 6'd63) ? S_LEVEL_END : S_FETCH;
         end
         S_LEVEL_END:         state_nxt = (level == LAST_LEVEL) ? S_GAME_DONE : S_TITLE;
         default:             state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      level_nxt      = level;
      cursor_nxt     = cursor;
      errors_nxt     = errors;
      txt_addr_nxt   = txt_addr;
      title_cnt_nxt  = title_cnt;
      exp_nxt        = exp_q;
      pend_nxt       = pend;
      key_ok_nxt     = 1'b0;
      key_bad_nxt    = 1'b0;
      level_done_nxt = 1'b0;
      unique case (state)
         S_IDLE, S_GAME_DONE: begin
            pend_nxt = '0;
            if (start) begin
               level_nxt     = 2'd1;
               cursor_nxt    = '0;
               errors_nxt    = '0;
               title_cnt_nxt = '0;
            end
         end
         S_TITLE: begin
            title_cnt_nxt = title_cnt + CW'(1);
            pend_nxt      = '0;
         end
         S_FETCH:     txt_addr_nxt = {level, cursor};
         S_CHECK_END: exp_nxt      = exp_char;
         S_WAIT_KEY: begin
            pend_nxt = '0;
            if (cur_key.vld) begin
               if (key_match) begin
                  key_ok_nxt = 1'b1;
                  if (cursor != 6'd63) cursor_nxt = cursor + 6'd1;
               end else begin
                  key_bad_nxt = 1'b1;
                  if (errors != 8'hFF) errors_nxt = errors + 8'd1;
               end
            end
         end
         S_LEVEL_END: begin
            level_done_nxt = 1'b1;
            cursor_nxt     = '0;
            pend_nxt       = '0;
            if (level != LAST_LEVEL) begin
               level_nxt     = level + 2'd1;
               title_cnt_nxt = '0;
            end
         end
         default: ;
      endcase

      // Keys typed while the next character is still being fetched.
      if ((state == S_FETCH || state == S_CHECK_END) && key_valid) begin
         pend_nxt.vld   = 1'b1;
         pend_nxt.ascii = key_ascii;
      end

      unique case (state_nxt)
         S_IDLE:      screen_sel_nxt = 2'd0;
         S_TITLE:     screen_sel_nxt = 2'd1;
         S_GAME_DONE: screen_sel_nxt = 2'd3;
         default:     screen_sel_nxt = 2'd2;
      endcase
      game_done_nxt = (state_nxt == S_GAME_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level      <= '0;
         cursor     <= '0;
         errors     <= '0;
         txt_addr   <= '0;
         screen_sel <= '0;
         key_ok     <= 1'b0;
         key_bad    <= 1'b0;
         level_done <= 1'b0;
         game_done  <= 1'b0;
         title_cnt  <= '0;
         exp_q      <= '0;
         pend       <= '0;
      end else begin
         level      <= level_nxt;
         cursor     <= cursor_nxt;
         errors     <= errors_nxt;
         txt_addr   <= txt_addr_nxt;
         screen_sel <= screen_sel_nxt;
         key_ok     <= key_ok_nxt;
         key_bad    <= key_bad_nxt;
         level_done <= level_done_nxt;
         game_done  <= game_done_nxt;
         title_cnt  <= title_cnt_nxt;
         exp_q      <= exp_nxt;
         pend       <= pend_nxt;
      end
   end

endmodule

// File: tb/tb_typing_level_controller.sv
// Directed bench for typing_level_controller: a procedural timeline model of
// the game is compared against the DUT every cycle, plus literal spot checks.
module tb_typing_level_controller;

   localparam int TC = 10;
   localparam int NL = 3;

   logic       clk = 1'b0;
   logic       reset, start, key_valid;
   logic [7:0] key_ascii, exp_char, txt_addr, errors;
   logic [1:0] level, screen_sel;
   logic [5:0] cursor;
   logic       key_ok, key_bad, level_done, game_done;

   logic [7:0] rom [256];
   assign exp_char = rom[txt_addr];

   typing_level_controller #(.TITLE_CYCLES(TC), .NUM_LEVELS(NL)) dut (
      .clk(clk), .reset(reset), .start(start), .key_valid(key_valid),
      .key_ascii(key_ascii), .exp_char(exp_char), .txt_addr(txt_addr),
      .level(level), .cursor(cursor), .errors(errors), .screen_sel(screen_sel),
      .key_ok(key_ok), .key_bad(key_bad), .level_done(level_done),
      .game_done(game_done)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   string pg = "THE QUICK BROWN FOX JUMPS OVER THE LAZY DOG";

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, want);
      end
   endtask

   function automatic logic [7:0] lc(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
   endfunction

   function automatic logic [7:0] uc(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
   endfunction

   function automatic logic [7:0] l2_char(input int i);
      if (i == 0) return 8'h51;
      if (i == 5) return 8'h40;
      if (i == 6) return 8'h5B;
      return 8'h41 + 8'(i % 26);
   endfunction

   // ---------------- behavioural model: the game as a timeline ----------------
   logic [1:0] m_level = 0, m_screen = 0;
   logic [5:0] m_cursor = 0;
   logic [7:0] m_errors = 0, m_addr = 0;
   bit         m_key_ok = 0, m_key_bad = 0, m_level_done = 0, m_game_done = 0;
   bit         m_in_wait = 0;

   task automatic step(output bit ab);
      @(posedge clk);
      m_key_ok = 0; m_key_bad = 0; m_level_done = 0;
      ab = reset;
      if (reset) begin
         m_level = 0; m_cursor = 0; m_errors = 0; m_addr = 0;
         m_screen = 0; m_game_done = 0; m_in_wait = 0;
      end
   endtask

   task automatic model_life();
      bit ab, pv, have, lvl_end;
      logic [7:0] pk, k, ch;
      pk = 0;
      forever begin
         do begin step(ab); if (ab) return; end while (!start);
         m_level = 1; m_cursor = 0; m_errors = 0; m_game_done = 0;
         forever begin
            m_screen = 1;
            repeat (TC) begin step(ab); if (ab) return; end
            m_screen = 2;
            lvl_end = 0;
            while (!lvl_end) begin
               pv = 0;
               step(ab); if (ab) return;
               if (key_valid) begin pv = 1; pk = key_ascii; end
               m_addr = {m_level, m_cursor};
               ch = rom[m_addr];
               step(ab); if (ab) return;
               if (key_valid) begin pv = 1; pk = key_ascii; end
               if (ch == 8'h00) lvl_end = 1;
               else begin
                  m_in_wait = 1;
                  while (m_in_wait) begin
                     step(ab); if (ab) return;
                     have = pv || key_valid;
                     k = pv ? pk : key_ascii;
                     pv = 0;
                     if (have) begin
                        if (uc(k) == ch) begin
                           m_key_ok = 1; m_in_wait = 0;
                           if (m_cursor == 63) lvl_end = 1;
                           else m_cursor = m_cursor + 1;
                        end else begin
                           m_key_bad = 1;
                           if (m_errors != 255) m_errors = m_errors + 1;
                        end
                     end
                  end
               end
            end
            step(ab); if (ab) return;
            m_level_done = 1; m_cursor = 0;
            if (m_level == 2'(NL)) begin m_screen = 3; m_game_done = 1; break; end
            m_level = m_level + 1;
         end
      end
   endtask

   initial forever model_life();

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (reset) begin
         chk("rst_level", 32'(level), 0);
         chk("rst_cursor", 32'(cursor), 0);
         chk("rst_errors", 32'(errors), 0);
         chk("rst_addr", 32'(txt_addr), 0);
         chk("rst_screen", 32'(screen_sel), 0);
         chk("rst_pulses", 32'({key_ok, key_bad, level_done, game_done}), 0);
      end else begin
         chk("level", 32'(level), 32'(m_level));
         chk("cursor", 32'(cursor), 32'(m_cursor));
         chk("errors", 32'(errors), 32'(m_errors));
         chk("txt_addr", 32'(txt_addr), 32'(m_addr));
         chk("screen_sel", 32'(screen_sel), 32'(m_screen));
         chk("key_ok", 32'(key_ok), 32'(m_key_ok));
         chk("key_bad", 32'(key_bad), 32'(m_key_bad));
         chk("level_done", 32'(level_done), 32'(m_level_done));
         chk("game_done", 32'(game_done), 32'(m_game_done));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int t = 0;
      while (!m_in_wait && t < 500) begin @(negedge clk); t++; end
      chk("wait_key_reached", 32'(m_in_wait), 1);
   endtask

   task automatic press(input logic [7:0] ch);
      wait_ready();
      key_valid = 1; key_ascii = ch;
      @(negedge clk);
      key_valid = 0;
   endtask

   initial begin
      reset = 0; start = 0; key_valid = 0; key_ascii = 0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[64] = 8'h41; rom[65] = 8'h42;
      for (int i = 0; i < 64; i++) rom[128 + i] = l2_char(i);
      for (int i = 0; i < pg.len(); i++) rom[192 + i] = 8'(pg[i]);

      #1 reset = 1;
      repeat (3) @(negedge clk);
      #1 reset = 0;
      repeat (5) @(negedge clk);
      chk("idle_level", 32'(level), 0);
      chk("idle_screen", 32'(screen_sel), 0);

      // title hold with stray keys
      start = 1; @(negedge clk); start = 0;
      for (int i = 0; i < TC; i++) begin
         chk("title_screen", 32'(screen_sel), 1);
         key_valid = (i == 3 || i == 9); key_ascii = 8'h5A;
         @(negedge clk);
      end
      key_valid = 0;
      chk("fetch_screen", 32'(screen_sel), 2);
      @(negedge clk);
      chk("first_addr", 32'(txt_addr), 32'h40);

      // level 1 "AB"
      press(8'h61); chk("l1_ok_a", 32'(key_ok), 1); chk("l1_cur1", 32'(cursor), 1);
      press(8'h42); chk("l1_ok_b", 32'(key_ok), 1); chk("l1_cur2", 32'(cursor), 2);
      repeat (3) @(negedge clk);
      chk("l1_done", 32'(level_done), 1);
      chk("l2_level", 32'(level), 2);
      chk("l2_title", 32'(screen_sel), 1);
      chk("l2_title_errs", 32'(errors), 0);

      // level 2: mistakes, saturation, uppercase boundaries, cursor 63 exit
      press(8'h58); chk("bad_x", 32'(key_bad), 1); chk("err1", 32'(errors), 1);
      chk("bad_x_cur", 32'(cursor), 0);
      press(8'h71); chk("ok_q", 32'(key_ok), 1); chk("ok_q_err", 32'(errors), 1);
      chk("ok_q_cur", 32'(cursor), 1);
      wait_ready();
      key_valid = 1; key_ascii = 8'h31;
      repeat (300) @(negedge clk);
      key_valid = 0;
      chk("err_sat", 32'(errors), 255);
      for (int i = 1; i < 64; i++) begin
         if (i == 5) begin press(8'h60); chk("grave_not_upcased", 32'(key_bad), 1); end
         if (i == 6) begin press(8'h7B); chk("brace_not_upcased", 32'(key_bad), 1); end
         press((i % 3 == 0) ? l2_char(i) : lc(l2_char(i)));
      end
      chk("cur63_hold", 32'(cursor), 63);
      chk("cur63_ok", 32'(key_ok), 1);
      @(negedge clk);
      chk("l2_done", 32'(level_done), 1);
      chk("l3_level", 32'(level), 3);
      chk("l3_cursor0", 32'(cursor), 0);

      // level 3 pangram with pending-key cases
      press(lc(8'(pg[0])));
      press(8'(pg[1]));
      chk("l3_cur2", 32'(cursor), 2);
      key_valid = 1; key_ascii = lc(8'(pg[2]));
      @(negedge clk); key_valid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("pend_ok", 32'(key_ok), 1);
      chk("pend_cur", 32'(cursor), 3);
      key_valid = 1; key_ascii = 8'h58;
      @(negedge clk); key_ascii = 8'h20;
      @(negedge clk); key_valid = 0;
      @(negedge clk);
      chk("pend_last_wins_ok", 32'(key_ok), 1);
      chk("pend_last_wins_bad", 32'(key_bad), 0);
      chk("pend_last_cur", 32'(cursor), 4);
      for (int i = 4; i < pg.len(); i++)
         press((i % 2 == 1) ? 8'(pg[i]) : lc(8'(pg[i])));
      repeat (3) @(negedge clk);
      chk("gd_flag", 32'(game_done), 1);
      chk("gd_screen", 32'(screen_sel), 3);
      chk("gd_level", 32'(level), 3);
      chk("gd_pulse", 32'(level_done), 1);
      chk("gd_errors", 32'(errors), 255);

      // restart from GAME_DONE
      start = 1; @(negedge clk); start = 0;
      chk("rs_level", 32'(level), 1);
      chk("rs_errors", 32'(errors), 0);
      chk("rs_screen", 32'(screen_sel), 1);
      chk("rs_gd", 32'(game_done), 0);
      press(8'h41);
      wait_ready();
      start = 1; repeat (2) @(negedge clk); start = 0;
      chk("start_ignored_lvl", 32'(level), 1);
      chk("start_ignored_scr", 32'(screen_sel), 2);
      press(8'h62);
      press(8'h51);
      for (int i = 1; i < 5; i++) press(lc(l2_char(i)));

      // reset in WAIT_KEY, level 2 cursor 5
      wait_ready();
      chk("pre_rst_level", 32'(level), 2);
      chk("pre_rst_cursor", 32'(cursor), 5);
      #1 reset = 1;
      @(negedge clk);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_cursor", 32'(cursor), 0);
      chk("mid_rst_screen", 32'(screen_sel), 0);
      #1 reset = 0;
      repeat (5) @(negedge clk);
      chk("post_rst_level", 32'(level), 0);
      chk("post_rst_screen", 32'(screen_sel), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
